// File: rtl/cdb_arb_pkg.sv
// Shared types and constants for the CDB writeback arbiter.
package cdb_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;
    localparam int PKT_DATA_W = 64;
    localparam int PKT_TAG_W  = 6;

    typedef logic [IDX_W-1:0] req_idx_t;

    // Packet shape at the default widths; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic [PKT_TAG_W-1:0]  tag;
        logic [PKT_DATA_W-1:0] data;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin pick over 4 requesters: rotate so ptr sits at bit 0,
// priority-encode the lowest set bit, then add ptr back.
module rr_pick4
    import cdb_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_valid,
    input  req_idx_t         ptr,
    output logic             any,
    output req_idx_t         idx
);

    logic [N_REQ-1:0] rot;
    req_idx_t         off;

    // Rotate, find the first requester at or after ptr, un-rotate.
    always_comb begin
        rot = '0;
        off = '0;
        for (int j = 0; j < N_REQ; j++)
            rot[j] = req_valid[req_idx_t'(j) + ptr];
        for (int j = N_REQ - 1; j >= 0; j--)
            if (rot[j]) off = req_idx_t'(j);
        any = |req_valid;
        idx = off + ptr;
    end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// Round-robin arbiter sharing the CDB writeback port among 4 units.
// Optional back-pressure stall counter enabled by CDB_ARB_PERF_EN.
module cdb_wb_arbiter
    import cdb_arb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][TAG_W-1:0]   req_tag,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          cdb_valid,
    output req_idx_t                      cdb_idx,
    output logic [N_REQ-1:0]              cdb_grant,
    output logic [TAG_W-1:0]              cdb_tag,
    output logic [DATA_W-1:0]             cdb_data,
    input  logic                          cdb_ready
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } pkt_t;

    req_idx_t rr_ptr;
    req_idx_t win;
    logic     any;
    logic     accept_en;
    logic     xfer;
    pkt_t     pkt_q;

    rr_pick4 u_pick (
        .req_valid (req_valid),
        .ptr       (rr_ptr),
        .any       (any),
        .idx       (win)
    );

    // Output register is free when empty or being drained this cycle.
    always_comb begin
        accept_en = !cdb_valid || cdb_ready;
        xfer      = accept_en && !flush && any;
        req_ready = '0;
        // Gated by reset_n so no requester sees a handshake while held in reset.
        if (xfer && reset_n) req_ready[win] = 1'b1;
        cdb_grant = '0;
        if (cdb_valid) cdb_grant[cdb_idx] = 1'b1;
    end

    assign cdb_tag  = pkt_q.tag;
    assign cdb_data = pkt_q.data;

    // Packet register and pointer: flush drops the packet, accept loads or empties, stall holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid <= 1'b0;
            cdb_idx   <= '0;
            pkt_q     <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (accept_en) begin
            if (any) begin
                cdb_valid  <= 1'b1;
                cdb_idx    <= win;
                pkt_q.tag  <= req_tag[win];
                pkt_q.data <= req_data[win];
                rr_ptr     <= win + req_idx_t'(1);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    // Saturating count of cycles where work was waiting but the CDB was blocked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if ((|req_valid) && !accept_en && !flush && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed self-checking bench for cdb_wb_arbiter.
module tb_cdb_wb_arbiter;
    import cdb_arb_pkg::*;

    localparam int DATA_W = 64;
    localparam int TAG_W  = 6;

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic                          flush;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0][TAG_W-1:0]   req_tag;
    logic [N_REQ-1:0][DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]              req_ready;
    logic                          cdb_valid;
    req_idx_t                      cdb_idx;
    logic [N_REQ-1:0]              cdb_grant;
    logic [TAG_W-1:0]              cdb_tag;
    logic [DATA_W-1:0]             cdb_data;
    logic                          cdb_ready;
`ifdef CDB_ARB_PERF_EN
    logic [15:0]                   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_wb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_idx   (cdb_idx),
        .cdb_grant (cdb_grant),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_ready (cdb_ready)
`ifdef CDB_ARB_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Check the registered CDB outputs for a valid packet from unit i.
    task automatic chk_cdb(input string tag, input int i);
        chk({tag, ".valid"}, 64'(cdb_valid), 64'd1);
        chk({tag, ".idx"},   64'(cdb_idx),   64'(i));
        chk({tag, ".grant"}, 64'(cdb_grant), 64'(4'b0001 << i));
        chk({tag, ".tag"},   64'(cdb_tag),   64'(req_tag[i]));
        chk({tag, ".data"},  64'(cdb_data),  req_data[i]);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        cdb_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            req_tag[i]  = TAG_W'(10 + i);
            req_data[i] = 64'hD000_0000_0000_0000 | 64'(i);
        end

        // 1. Reset then idle.
        #3;
        chk("rst.valid", 64'(cdb_valid), 64'd0);
        chk("rst.idx",   64'(cdb_idx),   64'd0);
        chk("rst.tag",   64'(cdb_tag),   64'd0);
        chk("rst.data",  cdb_data,       64'd0);
        chk("rst.grant", 64'(cdb_grant), 64'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst.ready_gated", 64'(req_ready), 64'd0);
        req_valid = '0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle.valid", 64'(cdb_valid), 64'd0);
            chk("idle.ready", 64'(req_ready), 64'd0);
            chk("idle.grant", 64'(cdb_grant), 64'd0);
        end

        // 2. All four valid: strict rotation 0,1,2,3,0,1,2,3.
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr.ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk_cdb("rr", k % 4);
        end

        // 3. Pointer wrap: park ptr at 3 by granting unit 2, then 4'b1001.
        req_valid = 4'b0100;
        #1;
        chk("wrap.pre", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("wrap.r3a", 64'(req_ready), 64'b1000);
        tick();
        chk_cdb("wrap.c3a", 3);
        chk("wrap.r0", 64'(req_ready), 64'b0001);
        tick();
        chk_cdb("wrap.c0", 0);
        chk("wrap.r3b", 64'(req_ready), 64'b1000);
        tick();
        chk_cdb("wrap.c3b", 3);
        req_valid = '0;
        tick();
        chk("drain.valid", 64'(cdb_valid), 64'd0);
        chk("drain.grant", 64'(cdb_grant), 64'd0);

        // 4. Back-pressure with packet idx 2, tag 5 (ptr is 0 here).
        req_tag[2] = TAG_W'(5);
        req_valid  = 4'b0100;
        #1;
        chk("bp.load", 64'(req_ready), 64'b0100);
        tick();
        chk_cdb("bp.cdb", 2);
        cdb_ready = 1'b0;
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp.ready0", 64'(req_ready), 64'd0);
            tick();
            chk_cdb("bp.hold", 2);
            chk("bp.hold.tag5", 64'(cdb_tag), 64'd5);
        end
`ifdef CDB_ARB_PERF_EN
        chk("bp.stall_cnt", 64'(stall_cnt), 64'd3);
`endif
        cdb_ready = 1'b1;
        #1;
        chk("bp.release", 64'(req_ready), 64'b1000);
        tick();
        chk_cdb("bp.next", 3);

        // 5. Flush while stalled with requests pending (ptr is 0).
        cdb_ready = 1'b0;
        req_valid = 4'b0110;
        flush     = 1'b1;
        #1;
        chk("fl.ready", 64'(req_ready), 64'd0);
        tick();
        chk("fl.valid", 64'(cdb_valid), 64'd0);
        chk("fl.grant", 64'(cdb_grant), 64'd0);
        flush = 1'b0;
`ifdef CDB_ARB_PERF_EN
        chk("fl.stall_cnt", 64'(stall_cnt), 64'd3);
`endif
        #1;
        chk("fl.ptr_kept", 64'(req_ready), 64'b0010);
        tick();
        chk_cdb("fl.next", 1);

        // 6. Async reset mid-stream (ptr is 2 here).
        cdb_ready = 1'b1;
        req_valid = 4'b1111;
        tick();
        chk_cdb("ar.pre", 2);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar.valid", 64'(cdb_valid), 64'd0);
        chk("ar.ready", 64'(req_ready), 64'd0);
`ifdef CDB_ARB_PERF_EN
        chk("ar.stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        tick();
        reset_n   = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("ar.first", 64'(req_ready), 64'b0010);
        tick();
        chk_cdb("ar.cdb", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
